instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline; feeds instructionDecode via the IF/ID register.
//  Owns the PC and runs a req/ack handshake to instruction memory (variable latency).
//  Consumes ID's branch/jump redirects, the flush and the hazard-unit stall.
//  Produces instruction and PC+4 with a valid bit.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_WORD   32'h0000_0000  instruction driven to IF/ID when not valid (sll $0,$0,0)
// PORTS
//  clk                   in   1   rising-edge clock
//  reset                 in   1   synchronous, active-high
//  stallInput            in   1   hazard unit: hold PC and IF/ID
//  ifFlushInput          in   1   ID: squash IF/ID contents
//  branchControlInput    in   1   ID: take branch
//  pcBranchInput         in   32  branch target
//  jumpInput             in   1   ID: take jump
//  pcJumpInput           in   32  jump target
//  imemReqOutput         out  1   fetch request
//  imemAddrOutput        out  32  fetch address (= PC)
//  imemAckInput          in   1   memory accepted req; imemDataInput valid this cycle
//  imemDataInput         in   32  fetched word
//  instructionOutput     out  32  IF/ID instruction
//  pc4Output             out  32  IF/ID PC+4
//  validOutput           out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, buffer empty; instructionOutput=NOP_WORD.
//   pc4Output=0, validOutput=0, imemReqOutput=0 in the reset cycle.
//  Handshake: req stays high with a stable addr until ack; an ack in the same cycle is legal.
//   Max rate is one instr/cycle; instr reaches IF/ID on the edge after ack.
//  Redirect = jumpInput | branchControlInput; target = jump ? pcJumpInput : pcBranchInput.
//   Jump has priority. Redirect is honoured regardless of stallInput.
//  FSM states:
//   FETCH: req=1, addr=pc.
//    ack, no redirect, no stall -> IF/ID<={data,pc+4,1}, pc<=pc+4.
//    ack, no redirect, stall -> buf<={data,pc+4}, go HOLD (IF/ID held).
//    ack + redirect -> data discarded, pc<=target, stay FETCH.
//    no ack + redirect -> redirPc<=target, go DISCARD.
//    no ack, no redirect -> IF/ID valid<=0 (bubble) unless stall (hold).
//   DISCARD: req=1, addr=old pc (unchanged).
//    New redirects overwrite redirPc.
//    ack -> data dropped, pc<=redirPc, go FETCH. IF/ID valid<=0 unless stall.
//   HOLD: req=0.
//    redirect -> buffer dropped, pc<=target, go FETCH.
//    else when stall=0 -> IF/ID<=buf with valid=1, pc<=pc+4, go FETCH.
//  Flush: ifFlushInput -> IF/ID valid<=0, instructionOutput<=NOP_WORD next edge.
//   Overrides stall and any load. Does not touch PC, FSM or buffer.
//  PC arithmetic mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
//  Target bits [1:0] are ignored (forced to 0).
//  Reset mid-request: req drops in the reset cycle; a late ack afterwards is ignored.
//   Memory must abort on reset.
// CONFIGURATION
//  FETCH_PERF_COUNT_EN defined: adds outputs fetchCountOutput[31:0] and discardCountOutput[31:0].
//   fetchCount +1 per instr loaded into IF/ID with valid=1 (incl. from buffer).
//   discardCount +1 per acked word dropped (redirect/DISCARD/HOLD drop).
//   Both reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  Reset, ack tied 1, mem[i]=i -> addr 0,4,8 on consecutive cycles.
//   IF/ID shows instr 0 with pc4=4 one cycle after the first req.
//  Ack delayed 3 cycles at addr 8 -> addr held at 8 for 4 cycles, 3 bubbles (valid=0).
//   Then instr 8 with pc4=12.
//  Branch to 0x40 while waiting for ack at 0x10 -> addr held 0x10 until ack.
//   Word dropped; next req 0x40; discardCount=1 with FETCH_PERF_COUNT_EN.
//  Stall during ack at 0x20 -> req drops, IF/ID held for the stall.
//   On release IF/ID=word@0x20, pc4=0x24, next req 0x24.
//  Jump(0x100) and branch(0x200) in the same cycle -> next req 0x100.
//   ifFlushInput -> validOutput=0 and instructionOutput=NOP_WORD next cycle.
//  Reset asserted mid-request -> req=0, validOutput=0 in the reset cycle; next req at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Purpose
//   IF stage of the 5-stage MIPS pipeline. Owns the program counter and runs a
//   req/ack handshake to a variable-latency instruction memory. It honours
//   branch/jump redirects from ID, the IF/ID flush, and the hazard-unit stall.
//   It also drives the IF/ID register (instruction, PC+4, valid).
//
// Handshake (imem)
//   imemReqOutput is high with a stable imemAddrOutput until imemAckInput is
//   seen. imemAckInput may arrive in the same cycle as the request. On ack,
//   imemDataInput carries the word for imemAddrOutput in that cycle. The word
//   reaches IF/ID on the following clock edge. The peak rate is one word per
//   cycle. Acks are ignored while req is low. The memory must abort on reset.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   NOP_WORD   instruction presented on instructionOutput when IF/ID is not valid
//
// Ports
//   clk                 in   1   rising-edge clock
//   reset               in   1   synchronous, active-high
//   stallInput          in   1   hold PC and IF/ID
//   ifFlushInput        in   1   squash IF/ID contents
//   branchControlInput  in   1   take branch
//   pcBranchInput       in   32  branch target
//   jumpInput           in   1   take jump (priority over branch)
//   pcJumpInput         in   32  jump target
//   imemReqOutput       out  1   fetch request
//   imemAddrOutput      out  32  fetch address (= PC)
//   imemAckInput        in   1   memory accepted req, data valid this cycle
//   imemDataInput       in   32  fetched word
//   instructionOutput   out  32  IF/ID instruction
//   pc4Output           out  32  IF/ID PC+4
//   validOutput         out  1   IF/ID holds a real instruction
//   fetchStateOutput    out  2   current FSM state (debug observation)
//
// Configuration
//   FETCH_PERF_COUNT_EN  when defined, adds two outputs:
//     fetchCountOutput   [31:0]  instructions loaded into IF/ID with valid=1
//     discardCountOutput [31:0]  acked words that were dropped
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallInput,
   input  logic        ifFlushInput,
   input  logic        branchControlInput,
   input  logic [31:0] pcBranchInput,
   input  logic        jumpInput,
   input  logic [31:0] pcJumpInput,
   output logic        imemReqOutput,
   output logic [31:0] imemAddrOutput,
   input  logic        imemAckInput,
   input  logic [31:0] imemDataInput,
   output logic [31:0] instructionOutput,
   output logic [31:0] pc4Output,
   output logic        validOutput,
   output logic [1:0]  fetchStateOutput
`ifdef FETCH_PERF_COUNT_EN
   ,
   output logic [31:0] fetchCountOutput,
   output logic [31:0] discardCountOutput
`endif
);

   // FETCH   : request outstanding at pc_q
   // DISCARD : a redirect arrived while the request was still pending. The
   //           address must stay stable, so the request is finished and its
   //           word is thrown away.
   // HOLD    : a word was acked during a stall. It is parked in the buffer
   //           and the request is dropped until the stall releases.
   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DISCARD = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] redir_pc_q;
   logic [31:0] buf_instr_q;
   logic [31:0] buf_pc4_q;
   logic [31:0] ifid_instr_q;
   logic [31:0] ifid_pc4_q;
   logic        ifid_valid_q;

   logic        redirect;
   logic [31:0] redir_target;
   logic [31:0] pc_plus4;

   // IF/ID load decision for this cycle
   logic        ifid_load;
   logic [31:0] load_instr;
   logic [31:0] load_pc4;
   logic        word_drop;

   assign redirect = jumpInput | branchControlInput;
   // Jump wins over branch. Targets are word-aligned, so the low bits are cleared.
   assign redir_target = (jumpInput ? pcJumpInput : pcBranchInput) & 32'hFFFF_FFFC;
   assign pc_plus4     = pc_q + 32'd4;

   always_comb begin
      ifid_load  = 1'b0;
      load_instr = imemDataInput;
      load_pc4   = pc_plus4;
      word_drop  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (imemAckInput) begin
               if (redirect)         word_drop = 1'b1;
               else if (!stallInput) ifid_load = 1'b1;
            end
         end
         ST_DISCARD: begin
            if (imemAckInput) word_drop = 1'b1;
         end
         ST_HOLD: begin
            if (redirect) begin
               word_drop = 1'b1;
            end else if (!stallInput) begin
               ifid_load  = 1'b1;
               load_instr = buf_instr_q;
               load_pc4   = buf_pc4_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         redir_pc_q   <= RESET_PC;
         buf_instr_q  <= NOP_WORD;
         buf_pc4_q    <= 32'd0;
         ifid_instr_q <= NOP_WORD;
         ifid_pc4_q   <= 32'd0;
         ifid_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (imemAckInput) begin
                  if (redirect) begin
                     pc_q <= redir_target;
                  end else if (stallInput) begin
                     buf_instr_q <= imemDataInput;
                     buf_pc4_q   <= pc_plus4;
                     state_q     <= ST_HOLD;
                  end else begin
                     pc_q <= pc_plus4;
                  end
               end else if (redirect) begin
                  redir_pc_q <= redir_target;
                  state_q    <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (redirect) redir_pc_q <= redir_target;
               if (imemAckInput) begin
                  // A redirect arriving with the ack is the newest target.
                  pc_q    <= redirect ? redir_target : redir_pc_q;
                  state_q <= ST_FETCH;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  pc_q    <= redir_target;
                  state_q <= ST_FETCH;
               end else if (!stallInput) begin
                  pc_q    <= pc_plus4;
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_FETCH;
         endcase

         // The flush beats both stall and load. Without a load, IF/ID
         // bubbles unless the stall holds it.
         if (ifFlushInput) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_WORD;
         end else if (ifid_load) begin
            ifid_instr_q <= load_instr;
            ifid_pc4_q   <= load_pc4;
            ifid_valid_q <= 1'b1;
         end else if (!stallInput) begin
            ifid_valid_q <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] discard_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q   <= 32'd0;
         discard_cnt_q <= 32'd0;
      end else begin
         if (ifid_load && !ifFlushInput) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (word_drop)                  discard_cnt_q <= discard_cnt_q + 32'd1;
      end
   end

   assign fetchCountOutput   = fetch_cnt_q;
   assign discardCountOutput = discard_cnt_q;
`endif

   // Outputs are forced to their idle values during the reset cycle itself.
   // This drops an in-flight request immediately.
   assign imemReqOutput     = ~reset & (state_q != ST_HOLD);
   assign imemAddrOutput    = pc_q;
   assign instructionOutput = (reset | ~ifid_valid_q) ? NOP_WORD : ifid_instr_q;
   assign pc4Output         = reset ? 32'd0 : ifid_pc4_q;
   assign validOutput       = ~reset & ifid_valid_q;
   assign fetchStateOutput  = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//   Directed scenarios plus a random-ack stretch. Expected IF/ID contents are
//   pushed to exp_q when the bench drives the acked cycle. They are popped
//   whenever IF/ID presents a newly loaded valid instruction.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

   localparam int W = 64;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        stallInput = 1'b0;
   logic        ifFlushInput = 1'b0;
   logic        branchControlInput = 1'b0;
   logic [31:0] pcBranchInput = 32'd0;
   logic        jumpInput = 1'b0;
   logic [31:0] pcJumpInput = 32'd0;
   logic        imemAckInput = 1'b0;
   logic [31:0] imemDataInput;
   logic        imemReqOutput;
   logic [31:0] imemAddrOutput;
   logic [31:0] instructionOutput;
   logic [31:0] pc4Output;
   logic        validOutput;
   logic [1:0]  fetchStateOutput;
`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] fetchCountOutput;
   logic [31:0] discardCountOutput;
`endif

   instruction_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
      .clk                (clk),
      .reset              (reset),
      .stallInput         (stallInput),
      .ifFlushInput       (ifFlushInput),
      .branchControlInput (branchControlInput),
      .pcBranchInput      (pcBranchInput),
      .jumpInput          (jumpInput),
      .pcJumpInput        (pcJumpInput),
      .imemReqOutput      (imemReqOutput),
      .imemAddrOutput     (imemAddrOutput),
      .imemAckInput       (imemAckInput),
      .imemDataInput      (imemDataInput),
      .instructionOutput  (instructionOutput),
      .pc4Output          (pc4Output),
      .validOutput        (validOutput),
      .fetchStateOutput   (fetchStateOutput)
`ifdef FETCH_PERF_COUNT_EN
      ,
      .fetchCountOutput   (fetchCountOutput),
      .discardCountOutput (discardCountOutput)
`endif
   );

   // Memory contents are derived from the address so every word is distinct.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   assign imemDataInput = mem_word(imemAddrOutput);

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_word;
   int           n_cmp = 0;
   int           n_err = 0;
   logic         stall_seen = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] a);
      exp_q.push_back({mem_word(a), a + 32'd4});
   endtask

   // A valid output following a stalled edge is a held value, not a new load.
   always @(posedge clk) stall_seen <= stallInput;

   always @(negedge clk) begin
      if (validOutput && !stall_seen) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_word = exp_q.pop_front();
            check_eq("sb_instr", instructionOutput, exp_word[63:32]);
            check_eq("sb_pc4", pc4Output, exp_word[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Wait for the next falling edge and check req/addr there. Then step 1ns
   // so the caller can drive inputs for the next rising edge.
   task automatic nc(input logic [31:0] a, input logic r);
      @(negedge clk);
      check_eq("req", 32'(imemReqOutput), 32'(r));
      if (r) check_eq("addr", imemAddrOutput, a);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_req"},   32'(imemReqOutput), 32'd0);
      check_eq({tag, "_valid"}, 32'(validOutput), 32'd0);
      check_eq({tag, "_instr"}, instructionOutput, NOP_WORD);
      check_eq({tag, "_pc4"},   pc4Output, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   logic [31:0] a;

   initial begin
      // Reset state
      repeat (2) begin
         @(negedge clk);
         check_idle("reset");
      end
      #1 reset = 1'b0; imemAckInput = 1'b1; push_exp(RESET_PC);
      #1 check_eq("first_req", 32'(imemReqOutput), 32'd1);
      check_eq("first_addr", imemAddrOutput, RESET_PC);

      // Back-to-back fetch with ack tied high
      nc(32'd4, 1'b1); push_exp(32'd4);
      nc(32'd8, 1'b1); imemAckInput = 1'b0;

      // Ack delayed 3 cycles at 8: address held, three bubbles
      for (int i = 0; i < 3; i++) begin
         nc(32'd8, 1'b1);
         check_eq("bubble_valid", 32'(validOutput), 32'd0);
         check_eq("bubble_instr", instructionOutput, NOP_WORD);
      end
      imemAckInput = 1'b1; push_exp(32'd8);
      nc(32'd12, 1'b1); push_exp(32'd12);

      // Branch while the request at 0x10 is pending: 0x10 is dropped, then 0x40
      nc(32'h10, 1'b1);
      imemAckInput = 1'b0; branchControlInput = 1'b1; pcBranchInput = 32'h43;
      nc(32'h10, 1'b1); branchControlInput = 1'b0;
      nc(32'h10, 1'b1); imemAckInput = 1'b1;
      nc(32'h40, 1'b1);
      check_eq("discard_valid", 32'(validOutput), 32'd0);
`ifdef FETCH_PERF_COUNT_EN
      check_eq("discard_cnt1", discardCountOutput, 32'd1);
      check_eq("fetch_cnt4", fetchCountOutput, 32'd4);
`endif
      push_exp(32'h40);

      // Stall during the ack at 0x44: req drops, IF/ID holds 0x40
      nc(32'h44, 1'b1); stallInput = 1'b1;
      nc(32'h0, 1'b0); imemAckInput = 1'b0;
      check_eq("hold_valid", 32'(validOutput), 32'd1);
      check_eq("hold_instr", instructionOutput, mem_word(32'h40));
      nc(32'h0, 1'b0);
      check_eq("hold_instr2", instructionOutput, mem_word(32'h40));
      stallInput = 1'b0; imemAckInput = 1'b1; push_exp(32'h44);
      nc(32'h48, 1'b1); push_exp(32'h48);

      // Jump and branch together: the jump wins and the acked word is dropped
      nc(32'h4C, 1'b1);
      jumpInput = 1'b1; pcJumpInput = 32'h100;
      branchControlInput = 1'b1; pcBranchInput = 32'h200;
      nc(32'h100, 1'b1);
      check_eq("jump_bubble", 32'(validOutput), 32'd0);
`ifdef FETCH_PERF_COUNT_EN
      check_eq("discard_cnt2", discardCountOutput, 32'd2);
      check_eq("fetch_cnt7", fetchCountOutput, 32'd7);
`endif
      jumpInput = 1'b0; branchControlInput = 1'b0; push_exp(32'h100);

      // Flush squashes the load of 0x104; PC still advances
      nc(32'h104, 1'b1); ifFlushInput = 1'b1;
      nc(32'h108, 1'b1);
      check_eq("flush_valid", 32'(validOutput), 32'd0);
      check_eq("flush_instr", instructionOutput, NOP_WORD);
      ifFlushInput = 1'b0;

      // Reset in the middle of a pending request, followed by a late ack
      imemAckInput = 1'b0; reset = 1'b1;
      #1 check_idle("midreset");
      nc(32'h0, 1'b0); imemAckInput = 1'b1;
      nc(32'h0, 1'b0); reset = 1'b0; imemAckInput = 1'b0;
      nc(RESET_PC, 1'b1);
`ifdef FETCH_PERF_COUNT_EN
      check_eq("fetch_cnt_rst", fetchCountOutput, 32'd0);
      check_eq("discard_cnt_rst", discardCountOutput, 32'd0);
`endif
      imemAckInput = 1'b1; push_exp(RESET_PC);

      // Wrap: a jump to the top word (low bits ignored), whose PC+4 is 0
      nc(32'd4, 1'b1); jumpInput = 1'b1; pcJumpInput = 32'hFFFF_FFFF;
      nc(32'hFFFF_FFFC, 1'b1); jumpInput = 1'b0; push_exp(32'hFFFF_FFFC);
      nc(32'h0, 1'b1);

      // Random ack pattern, sequential stream
      a = 32'h0;
      for (int i = 0; i < 40; i++) begin
         imemAckInput = 1'($urandom_range(0, 1));
         if (imemAckInput) begin
            push_exp(a);
            a = a + 32'd4;
         end
         nc(a, 1'b1);
      end
      imemAckInput = 1'b0;
      repeat (3) nc(a, 1'b1);
      check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
